// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V control units: FSM states, opcodes,
// ALU control codes and immediate formats.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/funct3/funct7/op[5] to ALUControl.
// Shared with the single-cycle control unit.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // only R-type (op[5]=1) honours funct7 for sub; addi never subtracts
                    3'b000:  o_alu_control = ({i_op5, i_funct7} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath selects, write enables and the ALU operation.
module multicycle_ctrl_unit
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_alu_op   = ALUOP_ADD;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = ALUOP_SUB;
                PCWrite    = Zero;
                instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // reset overrides the current state: no writes, selects as in fetch
        if (reset) begin
            w_alu_op   = ALUOP_ADD;
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b10;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign ImmSrc = imm_src(op);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench for multicycle_ctrl_unit: directed per-cycle vectors are
// queued by the stimulus process and checked by a negedge monitor.
module tb_multicycle_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int unsigned checks = 0;
    int unsigned errors = 0;

    string       q_name[$];
    logic [3:0]  q_st[$];
    logic [17:0] q_out[$];

    multicycle_ctrl_unit #(.RESET_STATE(riscv_ctrl_pkg::S_FETCH)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc RegWrite ALUControl illegal_op instr_done
    function automatic logic [17:0] o(input logic p, input logic a, input logic m, input logic i,
                                      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] is, input logic rw, input logic [2:0] alu,
                                      input logic il, input logic dn);
        o = {p, a, m, i, rs, sa, sb, is, rw, alu, il, dn};
    endfunction

    // Monitor: every cycle the DUT presents a full output set; compare against queued expectation.
    always @(negedge clk) begin
        if (q_st.size() > 0) begin
            string       nm;
            logic [3:0]  est;
            logic [17:0] eout;
            logic [3:0]  ast;
            logic [17:0] aout;
            nm   = q_name.pop_front();
            est  = q_st.pop_front();
            eout = q_out.pop_front();
            ast  = dut.r_state;
            aout = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ImmSrc, RegWrite, ALUControl, illegal_op, instr_done};
            checks++;
            if (ast !== est || aout !== eout) begin
                errors++;
                $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                         nm, ast, aout, est, eout);
            end
        end
    end

    task automatic step(input string nm, input logic rst, input logic mr, input logic z,
                        input logic [3:0] est, input logic [17:0] eout);
        reset     = rst;
        mem_ready = mr;
        Zero      = z;
        q_name.push_back(nm);
        q_st.push_back(est);
        q_out.push_back(eout);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic [3:0] exst, input logic [1:0] sb,
                             input logic [2:0] alu);
        op = opc; funct3 = f3; funct7 = f7;
        step({nm, "_fetch"},  0, 1, 0, 0,    o(1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'b000,0,0));
        step({nm, "_decode"}, 0, 1, 0, 1,    o(0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'b000,0,0));
        step({nm, "_exec"},   0, 1, 0, exst, o(0,0,0,0,2'd0,2'd2,sb,  2'd0,0,alu,   0,0));
        step({nm, "_aluwb"},  0, 1, 0, 7,    o(0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'b000,0,1));
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        op = 7'b0000000; funct3 = 3'b000; funct7 = 1'b0;
        @(posedge clk);
        #1;
        step("reset_state", 1, 1, 0, 0, o(0,0,0,0,2'd2,2'd0,2'd2,2'd0,0,3'b000,0,0));

        // lw, no stalls: 0,1,2,3,4
        op = 7'b0000011; funct3 = 3'b010;
        step("lw_fetch",   0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'b000,0,0));
        step("lw_decode",  0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'b000,0,0));
        step("lw_memadr",  0, 1, 0, 2, o(0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,3'b000,0,0));
        step("lw_memread", 0, 1, 0, 3, o(0,1,0,0,2'd0,2'd0,2'd0,2'd0,0,3'b000,0,0));
        step("lw_memwb",   0, 1, 0, 4, o(0,0,0,0,2'd1,2'd0,2'd0,2'd0,1,3'b000,0,1));

        // sw with a fetch stall and three write-wait cycles
        op = 7'b0100011;
        step("sw_fetch_stall", 0, 0, 0, 0, o(0,0,0,0,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("sw_fetch",       0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("sw_decode",      0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd1,0,3'b000,0,0));
        step("sw_memadr",      0, 1, 0, 2, o(0,0,0,0,2'd0,2'd2,2'd1,2'd1,0,3'b000,0,0));
        for (int i = 0; i < 3; i++)
            step("sw_memwrite_wait", 0, 0, 0, 5, o(0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'b000,0,0));
        step("sw_memwrite_done", 0, 1, 0, 5, o(0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'b000,0,1));

        // ALU decode through R- and I-type paths
        alu_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 4'd6, 2'd0, 3'b001);
        alu_instr("i_add", 7'b0010011, 3'b000, 1'b1, 4'd8, 2'd1, 3'b000);
        alu_instr("r_slt", 7'b0110011, 3'b010, 1'b0, 4'd6, 2'd0, 3'b101);
        alu_instr("i_or",  7'b0010011, 3'b110, 1'b0, 4'd8, 2'd1, 3'b011);
        alu_instr("r_and", 7'b0110011, 3'b111, 1'b0, 4'd6, 2'd0, 3'b010);

        // jal
        op = 7'b1101111; funct3 = 3'b000; funct7 = 1'b0;
        step("jal_fetch",  0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd3,0,3'b000,0,0));
        step("jal_decode", 0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd3,0,3'b000,0,0));
        step("jal_jal",    0, 1, 0, 9, o(1,0,0,0,2'd0,2'd1,2'd2,2'd3,0,3'b000,0,0));
        step("jal_aluwb",  0, 1, 0, 7, o(0,0,0,0,2'd0,2'd0,2'd0,2'd3,1,3'b000,0,1));

        // beq taken then not taken
        op = 7'b1100011;
        step("beq1_fetch",  0, 1, 0, 0,  o(1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'b000,0,0));
        step("beq1_decode", 0, 1, 0, 1,  o(0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'b000,0,0));
        step("beq_taken",   0, 1, 1, 10, o(1,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'b001,0,1));
        step("beq0_fetch",  0, 1, 1, 0,  o(1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'b000,0,0));
        step("beq0_decode", 0, 1, 0, 1,  o(0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'b000,0,0));
        step("beq_nottaken",0, 1, 0, 10, o(0,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'b001,0,1));

        // illegal opcode
        op = 7'b0000000;
        step("ill_fetch",  0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'b000,0,0));
        step("ill_decode", 0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'b000,1,0));

        // reset held two cycles in the middle of a stalled store
        op = 7'b0100011;
        step("rsw_fetch",    0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("rsw_decode",   0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd1,0,3'b000,0,0));
        step("rsw_memadr",   0, 1, 0, 2, o(0,0,0,0,2'd0,2'd2,2'd1,2'd1,0,3'b000,0,0));
        step("rsw_memwrite", 0, 0, 0, 5, o(0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'b000,0,0));
        step("rsw_reset1",   1, 0, 0, 5, o(0,0,0,0,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("rsw_reset2",   1, 1, 0, 0, o(0,0,0,0,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("post_reset_fetch",  0, 1, 0, 0, o(1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'b000,0,0));
        step("post_reset_decode", 0, 1, 0, 1, o(0,0,0,0,2'd0,2'd1,2'd1,2'd1,0,3'b000,0,0));

        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && q_st.size() > 0; i++) @(posedge clk);
        checks++;
        if (q_st.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q_st.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
